// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply sequencer.
package hilo_pkg;

    localparam int   WORD_W = 32;
    localparam logic RD_LO  = 1'b0;
    localparam logic RD_HI  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } state_t;

    // Architectural write from mthi/mtlo.
    typedef struct packed {
        logic              hi_we;
        logic              lo_we;
        logic [WORD_W-1:0] wdata;
    } wr_req_t;

    // Product capture from the multiplier.
    typedef struct packed {
        logic              en;
        logic [WORD_W-1:0] hi;
        logic [WORD_W-1:0] lo;
    } cap_req_t;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO register pair: architectural write port, product capture port
// (capture wins over a write on the same edge) and the read mux.
module hilo_regs
    import hilo_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  wr_req_t           wr,
    input  cap_req_t          cap,
    input  logic              rd_sel,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] hi;
    logic [WORD_W-1:0] lo;

    // HI/LO update: capture has priority over mthi/mtlo.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (cap.en) begin
            hi <= cap.hi;
            lo <= cap.lo;
        end else begin
            if (wr.hi_we) hi <= wr.wdata;
            if (wr.lo_we) lo <= wr.wdata;
        end
    end

    // Read mux always shows the current register contents.
    always_comb begin
        rd_data = (rd_sel == RD_HI) ? hi : lo;
    end

endmodule

// File: rtl/hilo_ctrl.sv
// Multiply sequencer: launches the 32-cycle multiplier, stalls the pipeline
// until it finishes, captures the product into HI/LO and flags a hang.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mult_req,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [WORD_W-1:0] wdata,
    input  logic              rd_sel,
    output logic [WORD_W-1:0] rd_data,
    output logic              stall,
    output logic              err,
    output logic              mul_start,
    output logic [WORD_W-1:0] mul_operand1,
    output logic [WORD_W-1:0] mul_operand2,
    input  logic              mul_done,
    input  logic [WORD_W-1:0] mul_hi,
    input  logic [WORD_W-1:0] mul_lo
);

    // Counter must hold TIMEOUT, since it still increments on the abort edge.
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    wr_req_t          wr;
    cap_req_t         cap;

    // Sequencer FSM, busy counter, operand latch and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            mul_operand1 <= '0;
            mul_operand2 <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A busy multiplier just keeps the request waiting (and stalled).
                    if (mult_req && mul_done) begin
                        mul_operand1 <= op_a;
                        mul_operand2 <= op_b;
                        cnt          <= '0;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: state <= BUSY;
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mul_done) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Start is combinational so a reset edge can never also launch the multiplier.
    always_comb begin
        mul_start = (state == LAUNCH) && !reset;
    end

    // Pipeline freeze covers the request cycle and the whole operation.
    always_comb begin
        stall = (state != IDLE) || mult_req;
    end

    // Write and capture requests towards the register pair.
    always_comb begin
        wr.hi_we = mthi_we;
        wr.lo_we = mtlo_we;
        wr.wdata = wdata;
        cap.en   = (state == BUSY) && mul_done;
        cap.hi   = mul_hi;
        cap.lo   = mul_lo;
    end

    hilo_regs u_regs (
        .clock   (clock),
        .reset   (reset),
        .wr      (wr),
        .cap     (cap),
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed + randomized bench for hilo_ctrl with a behavioural 32-cycle multiplier.
`timescale 1ns/1ps
module tb_hilo_ctrl;

    logic        clock;
    logic        reset;
    logic        mult_req;
    logic [31:0] op_a, op_b;
    logic        mthi_we, mtlo_we;
    logic [31:0] wdata;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        stall, err, mul_start;
    logic [31:0] mul_operand1, mul_operand2;
    logic        mul_done;
    logic [31:0] mul_hi, mul_lo;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_err;
    logic        hang;

    hilo_ctrl #(.TIMEOUT(40)) dut (
        .clock        (clock),
        .reset        (reset),
        .mult_req     (mult_req),
        .op_a         (op_a),
        .op_b         (op_b),
        .mthi_we      (mthi_we),
        .mtlo_we      (mtlo_we),
        .wdata        (wdata),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .stall        (stall),
        .err          (err),
        .mul_start    (mul_start),
        .mul_operand1 (mul_operand1),
        .mul_operand2 (mul_operand2),
        .mul_done     (mul_done),
        .mul_hi       (mul_hi),
        .mul_lo       (mul_lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Full-width signed product of two 32-bit words.
    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Multiplier model: samples start while idle, busy for 32 edges, garbage
    // on the product outputs until done returns; 'hang' keeps it busy forever.
    logic [63:0] m_prod;
    int          m_rem;
    always @(posedge clock) begin
        if (reset) begin
            mul_done <= 1'b1;
            m_rem    <= 0;
        end else if (mul_done) begin
            if (mul_start) begin
                mul_done <= 1'b0;
                m_rem    <= 32;
                m_prod   <= smul(mul_operand1, mul_operand2);
                mul_hi   <= $urandom;
                mul_lo   <= $urandom;
            end
        end else if (!hang) begin
            if (m_rem == 1) begin
                mul_done         <= 1'b1;
                {mul_hi, mul_lo} <= m_prod;
            end
            m_rem <= m_rem - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        rd_sel = 1'b0;
        #1 check({tag, "_lo"}, rd_data, exp_lo);
        rd_sel = 1'b1;
        #1 check({tag, "_hi"}, rd_data, exp_hi);
    endtask

    // One multiply from a negedge; optional mthi in the request cycle.
    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic wr_hi, input logic [31:0] wd, input logic timeout);
        int          stall_n, start_n;
        logic [31:0] mid_hi, hi_before;
        mult_req = 1'b1; op_a = a; op_b = b;
        mthi_we = wr_hi; wdata = wd; rd_sel = 1'b1;
        #1 check({tag, "_stall_req"}, stall, 1'b1);
        hi_before = wr_hi ? wd : exp_hi;
        stall_n = 1; start_n = 0; mid_hi = 'x;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (i == 0) begin
                mult_req = 1'b0; mthi_we = 1'b0;
                #1;
                check({tag, "_opnd1"}, mul_operand1, a);
                check({tag, "_opnd2"}, mul_operand2, b);
            end
            if (mul_start) start_n++;
            if (i == 10) mid_hi = rd_data;
            if (!stall) break;
            stall_n++;
        end
        check({tag, "_start_cnt"}, start_n, 1);
        check({tag, "_stall_cycles"}, stall_n, timeout ? 42 : 35);
        check({tag, "_mid_hi"}, mid_hi, hi_before);
        if (timeout) begin
            exp_err = 1'b1;
            if (wr_hi) exp_hi = wd;
        end else begin
            {exp_hi, exp_lo} = smul(a, b);
        end
        check({tag, "_err"}, err, exp_err);
        check_regs(tag);
    endtask

    initial begin
        reset = 1'b1; mult_req = 1'b0; op_a = '0; op_b = '0;
        mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0; rd_sel = 1'b0;
        hang = 1'b0; exp_hi = '0; exp_lo = '0; exp_err = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);

        // Reset state: stall follows mult_req, no start during reset.
        mult_req = 1'b1;
        #1 check("rst_stall_req", stall, 1'b1);
        check("rst_start", mul_start, 1'b0);
        mult_req = 1'b0;
        #1 check("rst_stall", stall, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_opnd1", mul_operand1, 32'h0);
        reset = 1'b0;
        check_regs("rst");
        @(negedge clock);

        // Directed multiplies, including back-to-back launch.
        do_mult("m7x-3", 32'd7, 32'hFFFFFFFD, 1'b0, 32'h0, 1'b0);
        check("m7x-3_hi_const", exp_hi, 32'hFFFFFFFF);
        check("m7x-3_lo_const", {rd_sel, rd_data}, {1'b1, 32'hFFFFFFFF});
        rd_sel = 1'b0;
        #1 check("m7x-3_lo_val", rd_data, 32'hFFFFFFEB);
        @(negedge clock);
        do_mult("mmin", 32'h80000000, 32'h80000000, 1'b0, 32'h0, 1'b0);
        check("mmin_hi_val", rd_data, 32'h40000000);
        do_mult("m3x5", 32'd3, 32'd5, 1'b0, 32'h0, 1'b0);
        check("m3x5_hi_val", rd_data, 32'h0);

        // mthi in the same cycle as the request: visible during BUSY, then overwritten.
        do_mult("mthi2x2", 32'd2, 32'd2, 1'b1, 32'hDEADBEEF, 1'b0);
        rd_sel = 1'b0;
        #1 check("mthi2x2_lo_val", rd_data, 32'd4);

        // mthi/mtlo while idle.
        @(negedge clock);
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = $urandom;
        exp_hi = wdata; exp_lo = wdata;
        @(negedge clock);
        mthi_we = 1'b0;
        wdata = $urandom; exp_lo = wdata;
        @(negedge clock);
        mtlo_we = 1'b0;
        check_regs("mtx");

        // Hung multiplier: timeout, HI/LO unchanged, err sticky until reset.
        @(negedge clock);
        hang = 1'b1;
        do_mult("tmo", 32'd5, 32'd6, 1'b0, 32'h0, 1'b1);
        repeat (3) @(negedge clock);
        check("tmo_err_sticky", err, 1'b1);
        check("tmo_stall_idle", stall, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; hang = 1'b0;
        exp_hi = '0; exp_lo = '0; exp_err = 1'b0;
        #1 check("tmo_err_clr", err, 1'b0);
        check_regs("tmo_rst");
        @(negedge clock);

        // Reset while in LAUNCH: start must be masked and never sampled.
        mult_req = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(negedge clock);
        mult_req = 1'b0;
        #1 check("lrst_start_pre", mul_start, 1'b1);
        reset = 1'b1;
        #1 check("lrst_start_masked", mul_start, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1 check("lrst_stall", stall, 1'b0);
        check("lrst_mul_idle", mul_done, 1'b1);
        @(negedge clock);

        // Reset at BUSY cycle 10: back to IDLE, HI/LO cleared.
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h12345678;
        @(negedge clock);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        mult_req = 1'b1; op_a = 32'd11; op_b = 32'd13;
        @(negedge clock);
        mult_req = 1'b0;
        repeat (11) @(negedge clock);
        reset = 1'b1;
        #1 check("brst_start", mul_start, 1'b0);
        check("brst_stall_busy", stall, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        #1 check("brst_stall", stall, 1'b0);
        check("brst_mul_idle", mul_done, 1'b1);
        check_regs("brst");
        @(negedge clock);
        do_mult("post_rst", 32'hFFFF0001, 32'd1234567, 1'b0, 32'h0, 1'b0);

        // Randomized operands against the arithmetic reference.
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            do_mult("rnd", $urandom, $urandom, k[0], $urandom, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Multiply sequencer and HI/LO architectural register pair, placed between the CPU control unit and the 32-cycle Booth multiplier. It accepts a `mult` command with two operands and launches the multiplier with a single-cycle start pulse. It holds the pipeline stalled until the multiplier's `done` returns, then captures the 64-bit product into HI/LO. It also serves `mfhi`/`mflo` reads and `mthi`/`mtlo` writes, and flags a multiplier that never completes.

## Interface
- `TIMEOUT`, default 40: maximum BUSY cycles before abort; must exceed 33.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high. Also wired to the multiplier's reset.
- `mult_req`  in  1  control unit requests signed multiply `op_a*op_b`.
- `op_a`, `op_b`  in  32  multiplicand and multiplier.
- `mthi_we`, `mtlo_we`  in  1  write `wdata` into HI / LO.
- `wdata`  in  32  data for `mthi`/`mtlo`.
- `rd_sel`  in  1  0 = LO, 1 = HI.
- `rd_data`  out  32  combinational read of the selected register.
- `stall`  out  1  freeze pipeline.
- `err`  out  1  sticky timeout flag.
- `mul_start`  out  1  multiplier start.
- `mul_operand1`, `mul_operand2`  out  32  registered operands: op_a and op_b respectively.
- `mul_done`  in  1  multiplier idle/finished (high when idle).
- `mul_hi`, `mul_lo`  in  32  multiplier product halves.

## Operation
- Multiplier contract:
  - It samples `mul_start` at an edge where `mul_done`=1.
  - `mul_done` goes low after that edge and stays low for 32 edges.
  - It returns high with `mul_hi`/`mul_lo` holding the signed product.
  - `mul_start` is ignored while `mul_done`=0.
- FSM states: IDLE, LAUNCH, BUSY.
- IDLE
  - On `mult_req` && `mul_done`: latch `op_a`/`op_b` into the operand registers, clear the timeout counter, go to LAUNCH.
  - If `mult_req` arrives with `mul_done`=0, remain in IDLE; `stall` stays high.
- LAUNCH
  - `mul_start` = (state==LAUNCH) && !reset. It is combinational so a reset edge can never also launch the multiplier.
  - Always go to BUSY next.
- BUSY
  - Increment the counter each cycle.
  - If `mul_done`: HI<=`mul_hi`, LO<=`mul_lo`, go to IDLE.
  - Else if counter==`TIMEOUT`-1: set `err`, go to IDLE, leave HI/LO unchanged.
- `stall` = (state!=IDLE) || `mult_req`.
- `mthi_we`/`mtlo_we` take effect on any edge. A capture in the same edge overrides them. If a write and `mult_req` share an edge, the write lands and is later overwritten by the capture.
- `rd_data` always reflects the current HI/LO. Reads during BUSY return the old values; the stall makes that invisible to the pipeline.
- Arithmetic is done in the multiplier; this block only moves 32-bit words, with no extension or truncation.

## Timing
- Reset values:
  - state IDLE, HI=0, LO=0, operand registers 0, counter 0.
  - `err`=0, `mul_start`=0, `stall` = `mult_req`.
- Latency, with `mult_req` sampled at edge e0:
  - LAUNCH during e0..e1; the multiplier samples start at e1.
  - Product iterations at e2..e33.
  - Capture at e34, so HI/LO are valid and `stall` is low after e34.
  - `stall` is high for 34 cycles after e0, plus the request cycle itself.
- Back-to-back: a new `mult_req` in the cycle after capture launches immediately, since `mul_done`=1.
- Reset mid-operation:
  - Returns to IDLE next edge; HI/LO cleared.
  - The multiplier is cleared by the shared reset; `mul_start` is forced 0 during reset.
- `err` clears only on reset.

## Structure
- Package `hilo_pkg`:
  - state enum `{IDLE, LAUNCH, BUSY}`
  - `RD_LO`=0, `RD_HI`=1
  - `WORD_W`=32
- One sub-module, `hilo_regs`: HI/LO pair with write port, capture port, capture-over-write priority, and the read mux.
- The FSM, counter and operand registers live in `hilo_ctrl`.

## Test plan
- Reset, then read both registers: `rd_data`=0 for both selections; `stall`=0; `err`=0.
- `mult_req`, op_a=7, op_b=-3 (0xFFFFFFFD): `mul_start` exactly one cycle; `stall` high 35 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- op_a=op_b=0x80000000: HI=0x40000000, LO=0x00000000. Issue a second request the cycle after capture, 3*5: it launches without gap and LO=15, HI=0.
- `mthi` 0xDEADBEEF, then `mult_req` 2*2 in the same cycle: HI reads 0xDEADBEEF during BUSY, then becomes 0 with LO=4.
- Multiplier model holds `mul_done` low forever: `err` rises after 40 BUSY cycles; FSM returns to IDLE; HI/LO unchanged; `stall` drops.
- Assert reset at cycle 10 of BUSY: next edge IDLE, HI=LO=0; `mul_start` not asserted during reset; a subsequent multiply completes correctly.
